// File: rtl/lfsr_pkg.sv
// lfsr_pkg: mode constants and maximal-length tap table for lfsr_gen.
// Tap masks use bit (t-1) for tap t of the Fibonacci register.
package lfsr_pkg;

  localparam bit FIBONACCI = 1'b0;
  localparam bit GALOIS    = 1'b1;

  function automatic logic [31:0] tap_mask(input int unsigned width);
    logic [31:0] m;
    m = '0;
    unique case (width)
      3:  m = 32'h0000_0006;
      4:  m = 32'h0000_000C;
      5:  m = 32'h0000_0014;
      6:  m = 32'h0000_0030;
      7:  m = 32'h0000_0060;
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: one combinational LFSR shift, Fibonacci or Galois form.
// Shifts toward the MSB; the old MSB is the bit shifted out.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int GALOIS = 0
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next,
  output logic             shifted
);

  localparam logic [31:0]      FULL  = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] FMASK = FULL[WIDTH-1:0];
  // Galois taps: same polynomial, x^WIDTH dropped and the +1 term added
  localparam logic [WIDTH-1:0] GMASK = {FMASK[WIDTH-2:0], 1'b1};

  assign shifted = state[WIDTH-1];

  if (GALOIS == int'(lfsr_pkg::GALOIS)) begin : g_galois
    always_comb begin
      next = {state[WIDTH-2:0], 1'b0};
      if (state[WIDTH-1]) begin
        next = next ^ GMASK;
      end
    end
  end else begin : g_fib
    always_comb begin
      next = {state[WIDTH-2:0], ^(state & FMASK)};
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: multi-step maximal-length LFSR with seed load and zero-seed guard.
// Optional period counter and wrap pulse under LFSR_WRAP_FLAG_EN.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEPS  = 1,
  parameter int GALOIS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic [STEPS-1:0] bits,
  output logic             seed_err
`ifdef LFSR_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  logic [STEPS-1:0] shift_bits;
  logic [WIDTH-1:0] stepped;
  logic             seed_ok;

  assign seed_ok = |seed;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    if (i == 0) begin : g_first
      assign cur = out;
    end else begin : g_chain
      assign cur = g_step[i-1].nxt;
    end
    lfsr_step #(
      .WIDTH (WIDTH),
      .GALOIS(GALOIS)
    ) u_step (
      .state  (cur),
      .next   (nxt),
      .shifted(shift_bits[i])
    );
  end

  assign stepped = g_step[STEPS-1].nxt;

  // A zero seed is rejected so the register can never lock up
  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '1;
      bits     <= '0;
      seed_err <= 1'b0;
    end else begin
      seed_err <= load && !seed_ok;
      if (load) begin
        if (seed_ok) begin
          out  <= seed;
          bits <= '0;
        end
      end else if (en) begin
        out  <= stepped;
        bits <= shift_bits;
      end
    end
  end

`ifdef LFSR_WRAP_FLAG_EN
  localparam logic [WIDTH:0]   PERIOD = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ADV    = (WIDTH+1)'(STEPS);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   sum;
  logic             roll;

  assign sum  = {1'b0, cnt} + ADV;
  assign roll = (sum >= PERIOD);

  // Subtracting 2^W-1 equals adding one modulo 2^W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (seed_ok) begin
        cnt <= '0;
      end
    end else if (en) begin
      wrap <= roll;
      cnt  <= roll ? sum[WIDTH-1:0] + ONE : sum[WIDTH-1:0];
    end else begin
      wrap <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of lfsr_gen in Fibonacci, multi-step
// and Galois configurations against hand-computed state sequences.
module tb_lfsr_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en_a = 0, load_a = 0;
  logic [7:0] seed_a = '0, out_a;
  logic [0:0] bits_a;
  logic       err_a;

  logic       en_b = 0, load_b = 0;
  logic [7:0] seed_b = '0, out_b;
  logic [3:0] bits_b;
  logic       err_b;

  logic        en_c = 0, load_c = 0;
  logic [15:0] seed_c = '0, out_c;
  logic [0:0]  bits_c;
  logic        err_c;

`ifdef LFSR_WRAP_FLAG_EN
  logic wrap_a, wrap_b, wrap_c;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_out [0:400];
  logic       ref_bit [0:400];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .STEPS(1), .GALOIS(0)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .load(load_a), .seed(seed_a),
    .out(out_a), .bits(bits_a), .seed_err(err_a)
`ifdef LFSR_WRAP_FLAG_EN
    , .wrap(wrap_a)
`endif
  );

  lfsr_gen #(.WIDTH(8), .STEPS(4), .GALOIS(0)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .seed(seed_b),
    .out(out_b), .bits(bits_b), .seed_err(err_b)
`ifdef LFSR_WRAP_FLAG_EN
    , .wrap(wrap_b)
`endif
  );

  lfsr_gen #(.WIDTH(16), .STEPS(1), .GALOIS(1)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .load(load_c), .seed(seed_c),
    .out(out_c), .bits(bits_c), .seed_err(err_c)
`ifdef LFSR_WRAP_FLAG_EN
    , .wrap(wrap_c)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (out_a !== 8'hFF) begin
      bad++; $display("FAIL reset_out_a got %h want ff", out_a);
    end
    total++;
    if (bits_a !== 1'b0 || err_a !== 1'b0) begin
      bad++; $display("FAIL reset_bits_err got %b/%b want 0/0", bits_a, err_a);
    end
    total++;
    if (out_b !== 8'hFF || bits_b !== 4'h0) begin
      bad++; $display("FAIL reset_b got %h/%h want ff/0", out_b, bits_b);
    end
    total++;
    if (out_c !== 16'hFFFF) begin
      bad++; $display("FAIL reset_out_c got %h want ffff", out_c);
    end
`ifdef LFSR_WRAP_FLAG_EN
    total++;
    if (wrap_a !== 1'b0) begin
      bad++; $display("FAIL reset_wrap got %b want 0", wrap_a);
    end
`endif
  endtask

  task automatic test_sequence();
    logic [7:0] hand [1:7];
    hand = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1, 8'hC2, 8'h85};
    en_a = 1'b1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k <= 7) begin
        total++;
        if (out_a !== hand[k] || bits_a !== 1'b1) begin
          bad++;
          $display("FAIL seq_hand k=%0d got %h/%b want %h/1",
                   k, out_a, bits_a, hand[k]);
        end
      end
      total++;
      if (k < 255) begin
        if (out_a === 8'hFF || out_a === 8'h00) begin
          bad++;
          if (bad < 20) $display("FAIL seq_early k=%0d got %h", k, out_a);
        end
      end else if (out_a !== 8'hFF) begin
        bad++; $display("FAIL seq_period got %h want ff", out_a);
      end
`ifdef LFSR_WRAP_FLAG_EN
      total++;
      if (wrap_a !== (k == 255)) begin
        bad++;
        if (bad < 20) $display("FAIL seq_wrap k=%0d got %b", k, wrap_a);
      end
`endif
    end
    en_a = 1'b0;
  endtask

  task automatic test_hold();
    en_a = 1'b1;
    tick();
    tick();
    en_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (out_a !== 8'hFC || bits_a !== 1'b1) begin
        bad++; $display("FAIL hold got %h/%b want fc/1", out_a, bits_a);
      end
    end
  endtask

  task automatic test_load();
    load_a = 1'b1; seed_a = 8'h00;
    tick();
    load_a = 1'b0;
    total++;
    if (out_a !== 8'hFC || err_a !== 1'b1 || bits_a !== 1'b1) begin
      bad++; $display("FAIL zero_seed got %h/%b want fc/1", out_a, err_a);
    end
    tick();
    total++;
    if (out_a !== 8'hFC || err_a !== 1'b0) begin
      bad++; $display("FAIL err_pulse got %h/%b want fc/0", out_a, err_a);
    end
    load_a = 1'b1; seed_a = 8'h5A;
    tick();
    load_a = 1'b0;
    total++;
    if (out_a !== 8'h5A || bits_a !== 1'b0 || err_a !== 1'b0) begin
      bad++; $display("FAIL load_5a got %h/%b want 5a/0", out_a, bits_a);
    end
    en_a = 1'b1;
    tick();
    total++;
    if (out_a !== 8'hB4 || bits_a !== 1'b0) begin
      bad++; $display("FAIL after_5a_1 got %h/%b want b4/0", out_a, bits_a);
    end
    tick();
    total++;
    if (out_a !== 8'h69 || bits_a !== 1'b1) begin
      bad++; $display("FAIL after_5a_2 got %h/%b want 69/1", out_a, bits_a);
    end
    load_a = 1'b1; seed_a = 8'h00;
    tick();
    load_a = 1'b0; en_a = 1'b0;
    total++;
    if (out_a !== 8'h69 || err_a !== 1'b1) begin
      bad++; $display("FAIL zero_seed_en got %h/%b want 69/1", out_a, err_a);
    end
  endtask

  task automatic test_load_en();
    load_a = 1'b1; en_a = 1'b1; seed_a = 8'h01;
    tick();
    load_a = 1'b0;
    total++;
    if (out_a !== 8'h01 || bits_a !== 1'b0) begin
      bad++; $display("FAIL load_prio got %h/%b want 01/0", out_a, bits_a);
    end
    tick();
    en_a = 1'b0;
    total++;
    if (out_a !== 8'h02) begin
      bad++; $display("FAIL load_prio_next got %h want 02", out_a);
    end
  endtask

  task automatic test_steps();
    load_b = 1'b1; seed_b = 8'h01;
    tick();
    load_b = 1'b0; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    total++;
    if (out_b !== 8'h11 || bits_b !== 4'h0) begin
      bad++; $display("FAIL steps_hand01 got %h/%h want 11/0", out_b, bits_b);
    end
    load_b = 1'b1; seed_b = 8'hFF;
    tick();
    load_b = 1'b0; en_b = 1'b1;
    tick();
    en_b = 1'b0;
    total++;
    if (out_b !== 8'hF0 || bits_b !== 4'hF) begin
      bad++; $display("FAIL steps_handff got %h/%h want f0/f", out_b, bits_b);
    end
    load_a = 1'b1; seed_a = 8'h37;
    tick();
    load_a = 1'b0; en_a = 1'b1;
    ref_out[0] = 8'h37;
    ref_bit[0] = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      ref_out[k] = out_a;
      ref_bit[k] = bits_a[0];
    end
    en_a = 1'b0;
    load_b = 1'b1; seed_b = 8'h37;
    tick();
    load_b = 1'b0; en_b = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick();
      total++;
      if (out_b !== ref_out[4*n] ||
          bits_b !== {ref_bit[4*n], ref_bit[4*n-1],
                      ref_bit[4*n-2], ref_bit[4*n-3]}) begin
        bad++;
        if (bad < 20)
          $display("FAIL steps_ref n=%0d got %h want %h",
                   n, out_b, ref_out[4*n]);
      end
    end
    en_b = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] hand [1:5];
    hand = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    rst = 1'b1;
    tick();
    rst = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 37; k++) tick();
    total++;
    if (out_a === 8'hFF) begin
      bad++; $display("FAIL mid_state got %h want not ff", out_a);
    end
    rst = 1'b1; load_a = 1'b1; seed_a = 8'h5A;
    tick();
    rst = 1'b0; load_a = 1'b0;
    total++;
    if (out_a !== 8'hFF || bits_a !== 1'b0 || err_a !== 1'b0) begin
      bad++; $display("FAIL mid_reset got %h/%b want ff/0", out_a, bits_a);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (out_a !== hand[k]) begin
        bad++; $display("FAIL mid_restart k=%0d got %h want %h",
                        k, out_a, hand[k]);
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_galois();
    logic [15:0] hand [1:3];
    hand = '{16'h5FEF, 16'hBFDE, 16'hDFAD};
    rst = 1'b1;
    tick();
    rst = 1'b0; en_c = 1'b1;
    for (int k = 1; k <= 65535; k++) begin
      tick();
      if (k <= 3) begin
        total++;
        if (out_c !== hand[k]) begin
          bad++; $display("FAIL galois_hand k=%0d got %h want %h",
                          k, out_c, hand[k]);
        end
      end
      total++;
      if (out_c === 16'h0000) begin
        bad++;
        if (bad < 20) $display("FAIL galois_zero k=%0d got 0000", k);
      end
      total++;
      if (k < 65535) begin
        if (out_c === 16'hFFFF) begin
          bad++;
          if (bad < 20) $display("FAIL galois_early k=%0d got ffff", k);
        end
      end else if (out_c !== 16'hFFFF) begin
        bad++; $display("FAIL galois_period got %h want ffff", out_c);
      end
`ifdef LFSR_WRAP_FLAG_EN
      total++;
      if (wrap_c !== (k == 65535)) begin
        bad++;
        if (bad < 20) $display("FAIL galois_wrap k=%0d got %b", k, wrap_c);
      end
`endif
    end
    en_c = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_load();
    test_load_en();
    test_steps();
    test_reset_mid();
    test_galois();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
